// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scanner: segment encodings,
// the blank pattern and the default geometry.
package seven_seg_pkg;

    localparam int DIGITS_DEFAULT   = 4;
    localparam int PRESCALE_DEFAULT = 100000;

    // All segments off (segments are active-low).
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low segment patterns, bit 6 = segment a ... bit 0 = segment g.
    // Listed from nibble F down to nibble 0 so entry [n] decodes nibble n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0111000,  // F
        7'b0110000,  // E
        7'b1000010,  // d
        7'b0110001,  // C
        7'b1100000,  // b
        7'b0001000,  // A
        7'b0001100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

endpackage

// File: rtl/seg_decoder.sv
// Combinational hex-nibble to active-low seven-segment decoder.
module seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Straight table lookup; no state.
    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment display scanner with double-buffered display
// data (shadow/active), frame-synchronous updates and leading-zero blanking.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int DIGITS   = DIGITS_DEFAULT,
    parameter int PRESCALE = PRESCALE_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  blank_lz,
    output logic [DIGITS-1:0]     an,
    output logic [7:1]            seven,
    output logic                  dp_n,
    output logic                  pending,
    output logic                  frame_tick
);

    localparam int PW = $clog2(PRESCALE);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    logic [PW-1:0]          presc_reg;
    logic [IW-1:0]          idx_reg;
    logic                   tick_reg;

    logic [4*DIGITS-1:0]    shadow_value_reg;
    logic [DIGITS-1:0]      shadow_dp_reg;
    logic                   shadow_blz_reg;
    logic [4*DIGITS-1:0]    active_value_reg;
    logic [DIGITS-1:0]      active_dp_reg;
    logic                   active_blz_reg;
    logic                   pending_reg;

    logic [DIGITS-1:0]      an_reg;
    logic [6:0]             seven_reg;
    logic                   dp_n_reg;

    logic                   slot_end;
    logic                   frame_wrap;
    logic [DIGITS-1:0][3:0] active_nibbles;
    logic [DIGITS:0]        zero_above;
    logic [DIGITS-1:0]      blank_mask;
    logic [3:0]             cur_nibble;
    logic                   cur_dp;
    logic                   cur_blank;
    logic [6:0]             seg_dec;
    logic [DIGITS-1:0]      an_next;

    // The last cycle of a slot, and the last cycle of the last slot (frame wrap).
    assign slot_end   = enable && (presc_reg == PRESC_LAST);
    assign frame_wrap = slot_end && (idx_reg == IDX_LAST);

    // Prescaler, digit index and the frame pulse; everything parks at 0 when disabled.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc_reg <= '0;
            idx_reg   <= '0;
            tick_reg  <= 1'b0;
        end else if (!enable) begin
            presc_reg <= '0;
            idx_reg   <= '0;
            tick_reg  <= 1'b0;
        end else begin
            tick_reg <= frame_wrap;
            if (slot_end) begin
                presc_reg <= '0;
                idx_reg   <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
            end else begin
                presc_reg <= presc_reg + PW'(1);
            end
        end
    end

    // Double buffer: loads land in shadow and move to active only at a frame
    // wrap (or straight away while the display is disabled). A load on the
    // wrap cycle itself bypasses shadow so it is not delayed a whole frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shadow_value_reg <= '0;
            shadow_dp_reg    <= '0;
            shadow_blz_reg   <= 1'b0;
            active_value_reg <= '0;
            active_dp_reg    <= '0;
            active_blz_reg   <= 1'b0;
            pending_reg      <= 1'b0;
        end else begin
            if (load) begin
                shadow_value_reg <= value;
                shadow_dp_reg    <= dp;
                shadow_blz_reg   <= blank_lz;
            end
            if (load && frame_wrap) begin
                active_value_reg <= value;
                active_dp_reg    <= dp;
                active_blz_reg   <= blank_lz;
                pending_reg      <= 1'b0;
            end else if (pending_reg && (frame_wrap || !enable)) begin
                active_value_reg <= shadow_value_reg;
                active_dp_reg    <= shadow_dp_reg;
                active_blz_reg   <= shadow_blz_reg;
                // A load arriving with the disabled-mode transfer stays queued.
                pending_reg      <= load;
            end else if (load) begin
                pending_reg      <= 1'b1;
            end
        end
    end

    // Leading-zero detection: zero_above[k] is set when nibbles k..DIGITS-1
    // are all zero. Digit 0 always stays lit so a zero value still shows "0".
    assign active_nibbles     = active_value_reg;
    assign zero_above[DIGITS] = 1'b1;
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
        assign zero_above[gi] = zero_above[gi+1] && (active_nibbles[gi] == 4'd0);
        if (gi == 0) begin : g_first
            assign blank_mask[gi] = 1'b0;
        end else begin : g_upper
            assign blank_mask[gi] = active_blz_reg && zero_above[gi];
        end
    end

    assign cur_nibble = active_nibbles[idx_reg];
    assign cur_dp     = active_dp_reg[idx_reg];
    assign cur_blank  = blank_mask[idx_reg];

    seg_decoder u_seg_decoder (
        .nibble (cur_nibble),
        .seg    (seg_dec)
    );

    // One-hot-low anode pattern for the current index.
    always_comb begin
        an_next          = '1;
        an_next[idx_reg] = 1'b0;
    end

    // Registered display drive; a blanked or disabled slot turns everything off.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            an_reg    <= '1;
            seven_reg <= SEG_BLANK;
            dp_n_reg  <= 1'b1;
        end else if (!enable || cur_blank) begin
            an_reg    <= '1;
            seven_reg <= SEG_BLANK;
            dp_n_reg  <= 1'b1;
        end else begin
            an_reg    <= an_next;
            seven_reg <= seg_dec;
            dp_n_reg  <= ~cur_dp;
        end
    end

    assign an         = an_reg;
    assign seven      = seven_reg;
    assign dp_n       = dp_n_reg;
    assign pending    = pending_reg;
    assign frame_tick = tick_reg;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: a 4-digit/prescale-4 instance for
// the main scenarios and an 8-digit/prescale-2 instance for geometry.
module tb_seven_seg_scanner;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;

    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp = '0;
    logic        blank_lz = 1'b0;
    logic [3:0]  an;
    logic [7:1]  seven;
    logic        dp_n;
    logic        pending;
    logic        frame_tick;

    logic        enable_b = 1'b0;
    logic        load_b = 1'b0;
    logic [31:0] value_b = '0;
    logic [7:0]  dp_b = '0;
    logic        blz_b = 1'b0;
    logic [7:0]  an_b;
    logic [7:1]  seven_b;
    logic        dp_n_b;
    logic        pending_b;
    logic        tick_b;

    int n_checks = 0;
    int n_fail   = 0;

    seven_seg_scanner #(.DIGITS(4), .PRESCALE(4)) dut (
        .CLK(CLK), .RST(RST), .enable(enable), .load(load), .value(value),
        .dp(dp), .blank_lz(blank_lz), .an(an), .seven(seven), .dp_n(dp_n),
        .pending(pending), .frame_tick(frame_tick)
    );

    seven_seg_scanner #(.DIGITS(8), .PRESCALE(2)) dut_b (
        .CLK(CLK), .RST(RST), .enable(enable_b), .load(load_b), .value(value_b),
        .dp(dp_b), .blank_lz(blz_b), .an(an_b), .seven(seven_b), .dp_n(dp_n_b),
        .pending(pending_b), .frame_tick(tick_b)
    );

    always #5 CLK = ~CLK;

    // Hand-derived segment codes
    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010,
                           S3 = 7'b0000110, S8 = 7'b0000000, S9 = 7'b0001100,
                           SA = 7'b0001000, SB = 7'b1100000, SC = 7'b0110001,
                           SD = 7'b1000010, SE = 7'b0110000, SF = 7'b0111000,
                           SX = 7'b1111111;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive a one-cycle load strobe after 'waits' falling edges.
    task automatic do_load(input int waits, input logic [15:0] v, input logic [3:0] d, input logic b);
        repeat (waits) @(negedge CLK);
        load = 1'b1; value = v; dp = d; blank_lz = b;
        $display("load value=%h dp=%b blank_lz=%b at %0t", v, d, b, $time);
        @(negedge CLK);
        load = 1'b0;
    endtask

    // Check n cycles of a frame; seg_e holds digit k at [7k+:7].
    task automatic check_frame(input int n, input logic [27:0] seg_e,
                               input logic [3:0] blank_e, input logic [3:0] dp_e);
        for (int t = 0; t < n; t++) begin
            int k;
            logic [3:0] an_e;
            @(negedge CLK);
            k = t / 4;
            an_e = 4'hF;
            if (!blank_e[k]) an_e[k] = 1'b0;
            check($sformatf("an t%0d", t), 32'(an), 32'(an_e));
            check($sformatf("seven t%0d", t), 32'(seven), blank_e[k] ? 32'(SX) : 32'(seg_e[7*k +: 7]));
            check($sformatf("dp_n t%0d", t), 32'(dp_n), blank_e[k] ? 32'd1 : 32'(!dp_e[k]));
            check($sformatf("frame_tick t%0d", t), 32'(frame_tick), 32'(t == 15));
        end
        $display("frame checked (%0d cycles) at %0t", n, $time);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] seg_b [8];
        seg_b[0] = SF; seg_b[1] = SE; seg_b[2] = SD; seg_b[3] = SC;
        seg_b[4] = SB; seg_b[5] = SA; seg_b[6] = S9; seg_b[7] = S8;

        // Reset state
        repeat (2) @(negedge CLK);
        check("rst an", 32'(an), 32'hF);
        check("rst seven", 32'(seven), 32'(SX));
        check("rst dp_n", 32'(dp_n), 32'd1);
        check("rst pending", 32'(pending), 32'd0);
        check("rst frame_tick", 32'(frame_tick), 32'd0);
        check("rst an_b", 32'(an_b), 32'hFF);
        RST = 1'b0;
        enable = 1'b1;

        // Frame 1: zeros; mid-frame load must not disturb it
        fork
            check_frame(16, {S0, S0, S0, S0}, 4'b0000, 4'b0000);
            begin
                do_load(5, 16'h12AF, 4'b0100, 1'b0);
                check("pending after load", 32'(pending), 32'd1);
            end
        join
        check("pending after wrap", 32'(pending), 32'd0);

        // Frame 2: 12AF with dp on digit 2
        check_frame(16, {S1, S2, SA, SF}, 4'b0000, 4'b0100);

        // Frame 3: load 0030 with blanking at frame start; display unchanged
        fork
            check_frame(16, {S1, S2, SA, SF}, 4'b0000, 4'b0100);
            begin
                do_load(0, 16'h0030, 4'b0000, 1'b1);
                check("pending 0030", 32'(pending), 32'd1);
            end
        join
        check("pending 0030 cleared", 32'(pending), 32'd0);

        // Frame 4: digits 3,2 blanked; then queue 0000 with blanking
        fork
            check_frame(16, {SX, SX, S3, S0}, 4'b1100, 4'b0000);
            do_load(3, 16'h0000, 4'b0000, 1'b1);
        join

        // Frame 5: only digit 0 lit; three loads, last one on the wrap cycle
        fork
            check_frame(16, {SX, SX, SX, S0}, 4'b1110, 4'b0000);
            begin
                do_load(2, 16'h1111, 4'b0000, 1'b0);
                do_load(3, 16'h2222, 4'b0000, 1'b0);
                check("pending 2222", 32'(pending), 32'd1);
                do_load(8, 16'h3333, 4'b0000, 1'b0);
                check("pending wrap load", 32'(pending), 32'd0);
            end
        join

        // Frame 6: 3333; reset during digit-2 slot with a load pending
        fork
            check_frame(10, {S3, S3, S3, S3}, 4'b0000, 4'b0000);
            begin
                do_load(1, 16'h5555, 4'b0000, 1'b0);
                check("pending 5555", 32'(pending), 32'd1);
            end
        join
        #2 RST = 1'b1;
        #1;
        check("async rst an", 32'(an), 32'hF);
        check("async rst seven", 32'(seven), 32'(SX));
        check("async rst dp_n", 32'(dp_n), 32'd1);
        check("async rst pending", 32'(pending), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        check_frame(16, {S0, S0, S0, S0}, 4'b0000, 4'b0000);
        check("pending after rst frame", 32'(pending), 32'd0);

        // Disabled: blank outputs, immediate transfer of a load
        enable = 1'b0;
        @(negedge CLK);
        check("dis an", 32'(an), 32'hF);
        check("dis seven", 32'(seven), 32'(SX));
        check("dis dp_n", 32'(dp_n), 32'd1);
        check("dis frame_tick", 32'(frame_tick), 32'd0);
        do_load(0, 16'hBEEF, 4'b0001, 1'b0);
        check("dis pending set", 32'(pending), 32'd1);
        @(negedge CLK);
        check("dis pending cleared", 32'(pending), 32'd0);
        check("dis an held", 32'(an), 32'hF);
        enable = 1'b1;
        check_frame(16, {SB, SE, SE, SF}, 4'b0000, 4'b0001);

        // 8-digit, prescale-2 instance
        enable = 1'b0;
        load_b = 1'b1; value_b = 32'h89ABCDEF; dp_b = 8'h00; blz_b = 1'b0;
        $display("load_b value=%h at %0t", value_b, $time);
        @(negedge CLK);
        load_b = 1'b0;
        check("b pending set", 32'(pending_b), 32'd1);
        @(negedge CLK);
        check("b pending cleared", 32'(pending_b), 32'd0);
        enable_b = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int t = 0; t < 16; t++) begin
                logic [7:0] an_e;
                @(negedge CLK);
                an_e = 8'hFF;
                an_e[t/2] = 1'b0;
                check($sformatf("b an f%0d t%0d", f, t), 32'(an_b), 32'(an_e));
                check($sformatf("b seven f%0d t%0d", f, t), 32'(seven_b), 32'(seg_b[t/2]));
                check($sformatf("b dp_n f%0d t%0d", f, t), 32'(dp_n_b), 32'd1);
                check($sformatf("b tick f%0d t%0d", f, t), 32'(tick_b), 32'(t == 15));
            end
            $display("frame_b %0d checked at %0t", f, $time);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
